// File: rtl/rv_alu1_skid.sv
`default_nettype none
// ============================================================================
//  Module   : rv_alu1_skid
//  Purpose  : ALU operand stage behind a two-entry head/skid buffer, with
//             operand bypass and jump/branch target generation on the head.
//  Revision : 1.0
// ============================================================================
module rv_alu1_skid #(
   parameter int IADDR_SPACE_BITS = 32,
   parameter int NUM_FWD          = 2,
   parameter int CTRL_W           = 8
) (
   input  logic                          i_clk,
   input  logic                          i_reset_n,
   input  logic                          i_flush,
   input  logic                          i_valid,
   output logic                          o_ready,
   output logic                          o_valid,
   input  logic                          i_ready,
   input  logic [IADDR_SPACE_BITS-1:0]   i_pc,
   input  logic [IADDR_SPACE_BITS-1:0]   i_pc_next,
   input  logic [IADDR_SPACE_BITS-1:0]   i_ret_addr,
   input  logic [4:0]                    i_rs1,
   input  logic [4:0]                    i_rs2,
   input  logic [4:0]                    i_rd,
   input  logic [31:0]                   i_imm_i,
   input  logic [31:0]                   i_imm_j,
   input  logic [CTRL_W-1:0]             i_ctrl,
   input  logic [2:0]                    i_funct3,
   input  logic                          i_op1_pc,
   input  logic                          i_op1_zero,
   input  logic                          i_op2_i,
   input  logic                          i_op2_j,
   input  logic                          i_inst_jal,
   input  logic                          i_inst_jalr,
   input  logic                          i_inst_mret,
   input  logic                          i_inst_branch,
   input  logic                          i_inst_store,
   input  logic                          i_reg_write,
   input  logic                          i_to_trap,
   input  logic                          i_branch_pred,
   input  logic [31:0]                   i_reg1_data,
   input  logic [31:0]                   i_reg2_data,
   input  logic [NUM_FWD-1:0]            i_fwd_valid,
   input  logic [5*NUM_FWD-1:0]          i_fwd_rd,
   input  logic [32*NUM_FWD-1:0]         i_fwd_data,
   output logic [31:0]                   o_op1,
   output logic [31:0]                   o_op2,
   output logic [IADDR_SPACE_BITS-1:0]   o_pc_target,
   output logic [31:0]                   o_reg_data1,
   output logic [31:0]                   o_reg_data2,
   output logic [IADDR_SPACE_BITS-1:0]   o_pc,
   output logic [IADDR_SPACE_BITS-1:0]   o_pc_next,
   output logic [4:0]                    o_rs1,
   output logic [4:0]                    o_rs2,
   output logic [4:0]                    o_rd,
   output logic [CTRL_W-1:0]             o_ctrl,
   output logic [2:0]                    o_funct3,
   output logic                          o_store,
   output logic                          o_reg_write,
   output logic                          o_inst_branch,
   output logic                          o_to_trap,
   output logic                          o_branch_pred,
   output logic                          o_inst_jal_jalr
);

   localparam int A = IADDR_SPACE_BITS;

   localparam logic [1:0] c_h_keep    = 2'd0;
   localparam logic [1:0] c_h_from_in = 2'd1;
   localparam logic [1:0] c_h_from_s  = 2'd2;

   typedef struct packed {
      logic [A-1:0]      pc;
      logic [A-1:0]      pc_next;
      logic [A-1:0]      ret_addr;
      logic [4:0]        rs1;
      logic [4:0]        rs2;
      logic [4:0]        rd;
      logic [31:0]       imm_i;
      logic [31:0]       imm_j;
      logic [CTRL_W-1:0] ctrl;
      logic [2:0]        funct3;
      logic              op1_pc;
      logic              op1_zero;
      logic              op2_i;
      logic              op2_j;
      logic              jal;
      logic              jalr;
      logic              mret;
      logic              branch;
      logic              store;
      logic              reg_write;
      logic              to_trap;
      logic              branch_pred;
   } entry_t;

   entry_t     w_in;
   entry_t     r_h;
   entry_t     r_s;
   logic       r_h_vld;
   logic       r_s_vld;
   logic       r_ready;

   logic       w_xfer_in;
   logic       w_xfer_out;
   logic       w_h_free;
   logic       w_h_vld_nxt;
   logic       w_s_vld_nxt;
   logic       w_s_load;
   logic [1:0] w_h_sel;

   assign w_in = '{
      pc:        i_pc,
      pc_next:   i_pc_next,
      ret_addr:  i_ret_addr,
      rs1:       i_rs1,
      rs2:       i_rs2,
      rd:        i_rd,
      imm_i:     i_imm_i,
      imm_j:     i_imm_j,
      ctrl:      i_ctrl,
      funct3:    i_funct3,
      op1_pc:    i_op1_pc,
      op1_zero:  i_op1_zero,
      op2_i:     i_op2_i,
      op2_j:     i_op2_j,
      jal:       i_inst_jal,
      jalr:      i_inst_jalr,
      mret:      i_inst_mret,
      branch:    i_inst_branch,
      store:     i_inst_store,
      reg_write: i_reg_write,
      to_trap:   i_to_trap,
      branch_pred: i_branch_pred
   };

   assign w_xfer_in  = i_valid & r_ready;
   assign w_xfer_out = r_h_vld & i_ready;
   assign w_h_free   = ~r_h_vld | w_xfer_out;

   // Skid entry is always older than a new arrival, so it refills H first.
   always_comb begin
      w_h_vld_nxt = r_h_vld;
      w_s_vld_nxt = r_s_vld;
      w_h_sel     = c_h_keep;
      w_s_load    = 1'b0;
      if (w_h_free) begin
         if (r_s_vld) begin
            w_h_sel     = c_h_from_s;
            w_h_vld_nxt = 1'b1;
            w_s_load    = w_xfer_in;
            w_s_vld_nxt = w_xfer_in;
         end else begin
            w_h_sel     = w_xfer_in ? c_h_from_in : c_h_keep;
            w_h_vld_nxt = w_xfer_in;
         end
      end else if (w_xfer_in) begin
         w_s_load    = 1'b1;
         w_s_vld_nxt = 1'b1;
      end
      if (i_flush) begin
         w_h_vld_nxt = 1'b0;
         w_s_vld_nxt = 1'b0;
         w_h_sel     = c_h_keep;
         w_s_load    = 1'b0;
      end
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_h     <= '0;
         r_s     <= '0;
         r_h_vld <= 1'b0;
         r_s_vld <= 1'b0;
         r_ready <= 1'b1;
      end else begin
         r_h_vld <= w_h_vld_nxt;
         r_s_vld <= w_s_vld_nxt;
         r_ready <= ~w_s_vld_nxt;
         if (w_h_sel == c_h_from_in) begin
            r_h <= w_in;
         end else if (w_h_sel == c_h_from_s) begin
            r_h <= r_s;
         end
         if (w_s_load) begin
            r_s <= w_in;
         end
      end
   end

   // Bypass network: evaluated on the head every cycle.
   logic [4:0]  w_fwd_rd   [NUM_FWD];
   logic [31:0] w_fwd_data [NUM_FWD];

   for (genvar k = 0; k < NUM_FWD; k++) begin : g_fwd
      assign w_fwd_rd[k]   = i_fwd_rd[5*k +: 5];
      assign w_fwd_data[k] = i_fwd_data[32*k +: 32];
   end

   logic [31:0] w_rs1_val;
   logic [31:0] w_rs2_val;

   // Walk channels high to low so the lowest matching index wins.
   always_comb begin
      w_rs1_val = i_reg1_data;
      w_rs2_val = i_reg2_data;
      for (int k = NUM_FWD - 1; k >= 0; k--) begin
         if (i_fwd_valid[k] && (w_fwd_rd[k] == r_h.rs1) && (r_h.rs1 != 5'd0)) begin
            w_rs1_val = w_fwd_data[k];
         end
         if (i_fwd_valid[k] && (w_fwd_rd[k] == r_h.rs2) && (r_h.rs2 != 5'd0)) begin
            w_rs2_val = w_fwd_data[k];
         end
      end
   end

   logic [A-1:0] w_jalr_sum;
   logic [A-1:0] w_rel_sum;

   assign w_jalr_sum = w_rs1_val[A-1:0] + r_h.imm_i[A-1:0];
   assign w_rel_sum  = r_h.pc + r_h.imm_j[A-1:0];

   always_comb begin
      if (r_h.mret) begin
         o_pc_target = r_h.ret_addr;
      end else if (r_h.jalr) begin
         o_pc_target = {w_jalr_sum[A-1:1], 1'b0};
      end else begin
         o_pc_target = w_rel_sum;
      end
   end

   always_comb begin
      if (r_h.op1_pc) begin
         o_op1 = 32'(r_h.pc);
      end else if (r_h.op1_zero) begin
         o_op1 = 32'd0;
      end else begin
         o_op1 = w_rs1_val;
      end
      if (r_h.op2_i) begin
         o_op2 = r_h.imm_i;
      end else if (r_h.op2_j) begin
         o_op2 = r_h.imm_j;
      end else begin
         o_op2 = w_rs2_val;
      end
   end

   assign o_ready     = r_ready;
   assign o_valid     = r_h_vld;
   assign o_reg_data1 = w_rs1_val;
   assign o_reg_data2 = w_rs2_val;
   assign o_pc        = r_h.pc;
   assign o_pc_next   = r_h.pc_next;
   assign o_rs1       = r_h.rs1;
   assign o_rs2       = r_h.rs2;
   assign o_ctrl      = r_h.ctrl;
   assign o_funct3    = r_h.funct3;

   // Flags and rd are qualified so a stale head cannot cause side effects.
   assign o_rd            = r_h_vld ? r_h.rd : 5'd0;
   assign o_store         = r_h_vld & r_h.store;
   assign o_reg_write     = r_h_vld & r_h.reg_write;
   assign o_inst_branch   = r_h_vld & r_h.branch;
   assign o_to_trap       = r_h_vld & r_h.to_trap;
   assign o_branch_pred   = r_h_vld & r_h.branch_pred;
   assign o_inst_jal_jalr = r_h_vld & (r_h.jal | r_h.jalr | r_h.mret);

endmodule
`default_nettype wire

// File: tb/tb_rv_alu1_skid.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rv_alu1_skid
//  Purpose  : Directed self-checking bench for rv_alu1_skid (32- and 16-bit PC).
//  Revision : 1.0
// ============================================================================
module tb_rv_alu1_skid;

   logic        r_clk = 1'b0;
   logic        r_reset_n;
   logic        r_flush, r_valid, r_ready_in;
   logic [31:0] r_pc, r_pc_next, r_ret_addr;
   logic [4:0]  r_rs1, r_rs2, r_rd;
   logic [31:0] r_imm_i, r_imm_j;
   logic [7:0]  r_ctrl;
   logic [2:0]  r_funct3;
   logic        r_op1_pc, r_op1_zero, r_op2_i, r_op2_j;
   logic        r_jal, r_jalr, r_mret, r_branch, r_store, r_reg_write, r_to_trap, r_bpred;
   logic [31:0] r_reg1, r_reg2;
   logic [1:0]  r_fwd_valid;
   logic [9:0]  r_fwd_rd;
   logic [63:0] r_fwd_data;

   logic        w_ready, w_valid;
   logic [31:0] w_op1, w_op2, w_pc_target, w_rd1, w_rd2, w_pc, w_pc_next;
   logic [4:0]  w_rs1, w_rs2, w_rd;
   logic [7:0]  w_ctrl;
   logic [2:0]  w_funct3;
   logic        w_store, w_reg_write, w_branch, w_to_trap, w_bpred, w_jj;

   logic        b_ready, b_valid;
   logic [31:0] b_op1, b_op2, b_rd1, b_rd2;
   logic [15:0] b_pc_target, b_pc, b_pc_next;
   logic [4:0]  b_rs1, b_rs2, b_rd;
   logic [7:0]  b_ctrl;
   logic [2:0]  b_funct3;
   logic        b_store, b_reg_write, b_branch, b_to_trap, b_bpred, b_jj;

   int n_total = 0;
   int n_bad   = 0;

   always #5 r_clk = ~r_clk;

   rv_alu1_skid #(.IADDR_SPACE_BITS(32), .NUM_FWD(2), .CTRL_W(8)) u_dut (
      .i_clk(r_clk), .i_reset_n(r_reset_n), .i_flush(r_flush),
      .i_valid(r_valid), .o_ready(w_ready), .o_valid(w_valid), .i_ready(r_ready_in),
      .i_pc(r_pc), .i_pc_next(r_pc_next), .i_ret_addr(r_ret_addr),
      .i_rs1(r_rs1), .i_rs2(r_rs2), .i_rd(r_rd),
      .i_imm_i(r_imm_i), .i_imm_j(r_imm_j), .i_ctrl(r_ctrl), .i_funct3(r_funct3),
      .i_op1_pc(r_op1_pc), .i_op1_zero(r_op1_zero), .i_op2_i(r_op2_i), .i_op2_j(r_op2_j),
      .i_inst_jal(r_jal), .i_inst_jalr(r_jalr), .i_inst_mret(r_mret),
      .i_inst_branch(r_branch), .i_inst_store(r_store), .i_reg_write(r_reg_write),
      .i_to_trap(r_to_trap), .i_branch_pred(r_bpred),
      .i_reg1_data(r_reg1), .i_reg2_data(r_reg2),
      .i_fwd_valid(r_fwd_valid), .i_fwd_rd(r_fwd_rd), .i_fwd_data(r_fwd_data),
      .o_op1(w_op1), .o_op2(w_op2), .o_pc_target(w_pc_target),
      .o_reg_data1(w_rd1), .o_reg_data2(w_rd2),
      .o_pc(w_pc), .o_pc_next(w_pc_next), .o_rs1(w_rs1), .o_rs2(w_rs2), .o_rd(w_rd),
      .o_ctrl(w_ctrl), .o_funct3(w_funct3), .o_store(w_store), .o_reg_write(w_reg_write),
      .o_inst_branch(w_branch), .o_to_trap(w_to_trap), .o_branch_pred(w_bpred),
      .o_inst_jal_jalr(w_jj)
   );

   rv_alu1_skid #(.IADDR_SPACE_BITS(16), .NUM_FWD(2), .CTRL_W(8)) u_dut16 (
      .i_clk(r_clk), .i_reset_n(r_reset_n), .i_flush(r_flush),
      .i_valid(r_valid), .o_ready(b_ready), .o_valid(b_valid), .i_ready(r_ready_in),
      .i_pc(r_pc[15:0]), .i_pc_next(r_pc_next[15:0]), .i_ret_addr(r_ret_addr[15:0]),
      .i_rs1(r_rs1), .i_rs2(r_rs2), .i_rd(r_rd),
      .i_imm_i(r_imm_i), .i_imm_j(r_imm_j), .i_ctrl(r_ctrl), .i_funct3(r_funct3),
      .i_op1_pc(r_op1_pc), .i_op1_zero(r_op1_zero), .i_op2_i(r_op2_i), .i_op2_j(r_op2_j),
      .i_inst_jal(r_jal), .i_inst_jalr(r_jalr), .i_inst_mret(r_mret),
      .i_inst_branch(r_branch), .i_inst_store(r_store), .i_reg_write(r_reg_write),
      .i_to_trap(r_to_trap), .i_branch_pred(r_bpred),
      .i_reg1_data(r_reg1), .i_reg2_data(r_reg2),
      .i_fwd_valid(r_fwd_valid), .i_fwd_rd(r_fwd_rd), .i_fwd_data(r_fwd_data),
      .o_op1(b_op1), .o_op2(b_op2), .o_pc_target(b_pc_target),
      .o_reg_data1(b_rd1), .o_reg_data2(b_rd2),
      .o_pc(b_pc), .o_pc_next(b_pc_next), .o_rs1(b_rs1), .o_rs2(b_rs2), .o_rd(b_rd),
      .o_ctrl(b_ctrl), .o_funct3(b_funct3), .o_store(b_store), .o_reg_write(b_reg_write),
      .o_inst_branch(b_branch), .o_to_trap(b_to_trap), .o_branch_pred(b_bpred),
      .o_inst_jal_jalr(b_jj)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge r_clk);
      #1;
   endtask

   task automatic clear_flags();
      r_op1_pc = 0; r_op1_zero = 0; r_op2_i = 0; r_op2_j = 0;
      r_jal = 0; r_jalr = 0; r_mret = 0; r_branch = 0; r_store = 0;
      r_reg_write = 0; r_to_trap = 0; r_bpred = 0;
      r_imm_i = 0; r_imm_j = 0;
   endtask

   task automatic offer(input logic [31:0] pc, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [4:0] rd);
      r_valid = 1'b1; r_pc = pc; r_pc_next = pc + 32'd4;
      r_rs1 = rs1; r_rs2 = rs2; r_rd = rd;
   endtask

   task automatic drain();
      r_valid = 1'b0; r_ready_in = 1'b1;
      tick(); tick();
   endtask

   initial begin
      r_reset_n = 1'b0; r_flush = 0; r_valid = 0; r_ready_in = 0;
      r_pc = 0; r_pc_next = 0; r_ret_addr = 32'h80;
      r_rs1 = 0; r_rs2 = 0; r_rd = 0; r_ctrl = 0; r_funct3 = 0;
      r_reg1 = 0; r_reg2 = 0; r_fwd_valid = 0; r_fwd_rd = 0; r_fwd_data = 0;
      clear_flags();
      #12;
      check("rst_valid", 32'(w_valid), 32'd0);
      check("rst_ready", 32'(w_ready), 32'd1);
      check("rst_pc", w_pc, 32'd0);
      check("rst_rd", 32'(w_rd), 32'd0);
      check("rst_target", w_pc_target, 32'd0);
      r_reset_n = 1'b1;
      tick();
      check("idle_valid", 32'(w_valid), 32'd0);

      // Streaming at full rate
      r_ready_in = 1'b1; r_reg_write = 1'b1; r_ctrl = 8'h5A; r_funct3 = 3'd5;
      offer(32'h100, 5'd1, 5'd2, 5'd3); tick();
      check("str0_pc", w_pc, 32'h100);
      check("str0_valid", 32'(w_valid), 32'd1);
      check("str0_ready", 32'(w_ready), 32'd1);
      check("str0_ctrl", 32'(w_ctrl), 32'h5A);
      check("str0_wr", 32'(w_reg_write), 32'd1);
      offer(32'h104, 5'd1, 5'd2, 5'd4); tick();
      check("str1_pc", w_pc, 32'h104);
      check("str1_ready", 32'(w_ready), 32'd1);
      offer(32'h108, 5'd1, 5'd2, 5'd5); tick();
      check("str2_pc", w_pc, 32'h108);
      check("str2_rd", 32'(w_rd), 32'd5);
      check("str2_ready", 32'(w_ready), 32'd1);
      r_valid = 1'b0; tick();
      check("str_end_valid", 32'(w_valid), 32'd0);
      check("str_end_wr", 32'(w_reg_write), 32'd0);
      check("str_end_rd", 32'(w_rd), 32'd0);

      // Back-pressure: A, B captured, C held upstream
      r_ready_in = 1'b0;
      offer(32'h200, 5'd1, 5'd2, 5'd3); tick();
      check("stA_pc", w_pc, 32'h200);
      check("stA_ready", 32'(w_ready), 32'd1);
      offer(32'h204, 5'd1, 5'd2, 5'd3); tick();
      check("stB_pc", w_pc, 32'h200);
      check("stB_ready", 32'(w_ready), 32'd0);
      offer(32'h208, 5'd1, 5'd2, 5'd3); tick();
      check("stC_pc", w_pc, 32'h200);
      check("stC_ready", 32'(w_ready), 32'd0);
      r_ready_in = 1'b1; tick();
      check("outB_pc", w_pc, 32'h204);
      check("outB_ready", 32'(w_ready), 32'd1);
      tick();
      check("outC_pc", w_pc, 32'h208);
      check("outC_valid", 32'(w_valid), 32'd1);
      r_valid = 1'b0; tick();
      check("st_end_valid", 32'(w_valid), 32'd0);

      // Bypass priority and late pickup on a stalled head
      r_ready_in = 1'b0; r_reg_write = 1'b0;
      r_op1_pc = 1; r_op1_zero = 1; r_op2_i = 1; r_op2_j = 1;
      r_imm_i = 32'h44; r_imm_j = 32'h88;
      offer(32'h300, 5'd5, 5'd7, 5'd1); tick();
      r_valid = 1'b0;
      r_reg1 = 32'hAAAA; r_reg2 = 32'hBBBB;
      r_fwd_valid = 2'b11; r_fwd_rd = {5'd5, 5'd5}; r_fwd_data = {32'h22, 32'h11};
      #1;
      check("fwd_lowest", w_rd1, 32'h11);
      check("fwd_rs2_miss", w_rd2, 32'hBBBB);
      check("op1_pc_prio", w_op1, 32'h300);
      check("op2_i_prio", w_op2, 32'h44);
      r_fwd_valid = 2'b10; #1;
      check("fwd_late_ch1", w_rd1, 32'h22);
      r_fwd_rd = {5'd7, 5'd5}; r_fwd_valid = 2'b11; #1;
      check("fwd_rs2_ch1", w_rd2, 32'h22);
      drain();
      r_ready_in = 1'b0; clear_flags();
      r_op1_zero = 1; r_op2_j = 1; r_imm_j = 32'h88;
      r_fwd_rd = {5'd0, 5'd0};
      offer(32'h310, 5'd0, 5'd0, 5'd1); tick();
      r_valid = 1'b0; #1;
      check("fwd_x0_rs1", w_rd1, 32'hAAAA);
      check("fwd_x0_rs2", w_rd2, 32'hBBBB);
      check("op1_zero", w_op1, 32'd0);
      check("op2_j", w_op2, 32'h88);
      r_fwd_valid = 2'b00;
      drain();

      // Target generation
      r_ready_in = 1'b0; clear_flags();
      r_jalr = 1; r_imm_i = 32'h4; r_reg1 = 32'h1003;
      offer(32'h400, 5'd3, 5'd0, 5'd1); tick();
      r_valid = 1'b0; #1;
      check("jalr_target", w_pc_target, 32'h1006);
      check("jalr_jj", 32'(w_jj), 32'd1);
      check("jalr_op1", w_op1, 32'h1003);
      drain();
      r_ready_in = 1'b0; clear_flags();
      r_mret = 1;
      offer(32'h404, 5'd3, 5'd0, 5'd0); tick();
      r_valid = 1'b0; #1;
      check("mret_target", w_pc_target, 32'h80);
      check("mret_jj", 32'(w_jj), 32'd1);
      drain();
      r_ready_in = 1'b0; clear_flags();
      r_imm_j = 32'h8;
      offer(32'hFFFC, 5'd0, 5'd0, 5'd0); tick();
      r_valid = 1'b0; #1;
      check("rel_target32", w_pc_target, 32'h10004);
      check("rel_target16", 32'(b_pc_target), 32'h0004);
      check("rel_jj", 32'(w_jj), 32'd0);
      drain();

      // Flush with skid full and a new offer pending
      r_ready_in = 1'b0; clear_flags(); r_reg_write = 1'b1;
      offer(32'h500, 5'd0, 5'd0, 5'd6); tick();
      offer(32'h504, 5'd0, 5'd0, 5'd6); tick();
      check("pre_flush_ready", 32'(w_ready), 32'd0);
      offer(32'h508, 5'd0, 5'd0, 5'd6); r_flush = 1'b1; tick();
      r_flush = 1'b0;
      check("flush_valid", 32'(w_valid), 32'd0);
      check("flush_ready", 32'(w_ready), 32'd1);
      check("flush_wr", 32'(w_reg_write), 32'd0);
      check("flush_rd", 32'(w_rd), 32'd0);
      r_valid = 1'b0; tick();
      check("flush_nocap", 32'(w_valid), 32'd0);

      // Asynchronous reset while stalled
      r_ready_in = 1'b0;
      offer(32'h600, 5'd0, 5'd0, 5'd9); tick();
      offer(32'h604, 5'd0, 5'd0, 5'd9); tick();
      r_valid = 1'b0;
      check("pre_rst_valid", 32'(w_valid), 32'd1);
      check("pre_rst_rd", 32'(w_rd), 32'd9);
      #2 r_reset_n = 1'b0;
      #1;
      check("arst_valid", 32'(w_valid), 32'd0);
      check("arst_ready", 32'(w_ready), 32'd1);
      check("arst_pc", w_pc, 32'd0);
      check("arst_rd", 32'(w_rd), 32'd0);
      #2 r_reset_n = 1'b1;
      r_ready_in = 1'b1; tick();
      check("post_rst_valid", 32'(w_valid), 32'd0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire

// File: doc/rv_alu1_skid.md
RV_ALU1_SKID -- requirements
Module: rv_alu1_skid

Interface
REQ-001 SHALL have parameter IADDR_SPACE_BITS, default 32: instruction address width, legal range 2..32.
REQ-002 SHALL have parameter NUM_FWD, default 2: number of operand bypass channels, legal range 1..4.
REQ-003 SHALL have parameter CTRL_W, default 8: opaque ALU control word width.
REQ-004 SHALL have the following ports:
- i_clk  in  1  clock; rising edge only.
- i_reset_n  in  1  asynchronous active-low reset.
- i_flush  in  1  synchronous pipeline flush.
- i_valid  in  1  upstream request.
- o_ready  out  1  upstream may transfer.
- o_valid  out  1  head entry valid.
- i_ready  in  1  downstream accepts head.
- i_pc, i_pc_next, i_ret_addr  in  IADDR_SPACE_BITS each  instruction PC, predicted next PC, mret return address.
- i_rs1, i_rs2, i_rd  in  5 each  register indices.
- i_imm_i, i_imm_j  in  32 each  immediates.
- i_ctrl  in  CTRL_W  ALU control.
- i_funct3  in  3  funct3.
- i_op1_pc, i_op1_zero, i_op2_i, i_op2_j  in  1 each  operand selects.
- i_inst_jal, i_inst_jalr, i_inst_mret, i_inst_branch, i_inst_store, i_reg_write, i_to_trap, i_branch_pred  in  1 each  instruction flags.
- i_reg1_data, i_reg2_data  in  32 each  register file read data for head rs1/rs2.
- i_fwd_valid  in  NUM_FWD  per-channel bypass valid.
- i_fwd_rd  in  5*NUM_FWD  per-channel destination index.
- i_fwd_data  in  32*NUM_FWD  per-channel result.
- o_op1, o_op2  out  32 each  resolved ALU operands.
- o_pc_target  out  IADDR_SPACE_BITS  jump/branch target.
- o_reg_data1, o_reg_data2  out  32 each  forwarded rs1/rs2 values.
- o_pc, o_pc_next, o_rs1, o_rs2, o_rd, o_ctrl, o_funct3, o_store, o_reg_write, o_inst_branch, o_to_trap, o_branch_pred  out  widths as inputs  head payload.
- o_inst_jal_jalr  out  1  head is jal, jalr or mret.

Function
REQ-005 SHALL hold a two-entry buffer: head register H plus skid register S, each with a valid bit.
REQ-006 SHALL drive o_ready = !S.valid, registered, with no combinational path from i_ready.
REQ-007 SHALL drive o_valid = H.valid; all o_* payload outputs SHALL reflect H.
REQ-008 Transfer in SHALL be defined as i_valid & o_ready; transfer out SHALL be defined as o_valid & i_ready.
REQ-009 On transfer in with H empty or H leaving this cycle, the entry SHALL load into H when S is empty, else S SHALL move to H and the new entry SHALL load into S.
REQ-010 On transfer in while H is held (valid & !i_ready), the entry SHALL load into S.
REQ-011 When H leaves and S is valid, S SHALL move to H; entry order SHALL be strictly FIFO.
REQ-012 Input-to-o_valid latency SHALL be 1 cycle when unstalled, giving sustained throughput of 1 entry per cycle.
REQ-013 Bypass: for rs1 (and independently rs2), the value SHALL come from the lowest-index channel k with i_fwd_valid[k] & i_fwd_rd[k]==rs & rs!=0, else from i_reg1_data/i_reg2_data; rs==0 SHALL never forward.
REQ-014 Bypass SHALL be combinational on H every cycle, so a stalled head picks up late results.
REQ-015 Operand 1 SHALL select: op1_pc -> zero-extended pc; else op1_zero -> 0; else forwarded rs1. op1_pc SHALL take priority.
REQ-016 Operand 2 SHALL select: op2_i -> imm_i; else op2_j -> imm_j; else forwarded rs2. op2_i SHALL take priority.
REQ-017 o_pc_target SHALL be: mret -> i_ret_addr; else jalr -> (forwarded rs1 + imm_i) with bit 0 cleared; else pc + imm_j. Immediates and rs1 SHALL be truncated to IADDR_SPACE_BITS and the sum SHALL wrap modulo 2^IADDR_SPACE_BITS.
REQ-018 i_flush SHALL clear H.valid and S.valid at the next edge, overriding simultaneous transfer in/out; o_ready SHALL be 1 the following cycle.
REQ-019 When o_valid=0, flag outputs (store, reg_write, inst_*, to_trap, branch_pred) SHALL read 0 and o_rd SHALL read 0.

Reset
REQ-020 Asserting i_reset_n low SHALL immediately clear H, S and all valid bits, and zero every payload register without waiting for i_clk.
REQ-021 During and after reset, o_valid SHALL be 0, o_ready SHALL be 1, and all registered outputs SHALL be 0 until the first transfer.
REQ-022 Reset asserted mid-stall SHALL discard both entries.

Verification
REQ-023 Streaming with i_ready=1 and pc 0x100, 0x104, 0x108 on consecutive cycles -> o_pc 0x100, 0x104, 0x108 one cycle later, o_ready held at 1.
REQ-024 i_ready=0 for 3 cycles with 3 offers -> entries A and B captured, o_ready=0 from cycle 2, C held upstream; after i_ready=1, outputs A, B, C in order.
REQ-025 Head rs1=5, fwd0 rd=5 data 0x11, fwd1 rd=5 data 0x22, both valid -> o_reg_data1=0x11; with rs1=0 and the same channels -> o_reg_data1=i_reg1_data.
REQ-026 jalr with rs1 data 0x1003 and imm_i 0x4 -> o_pc_target 0x1006; mret with ret_addr 0x80 -> 0x80; with IADDR_SPACE_BITS=16, pc 0xFFFC and imm_j 8 -> 0x0004.
REQ-027 Flush with S full and i_valid=1 -> next cycle o_valid=0 and o_ready=1, and the offered entry is not captured.
REQ-028 Async reset pulse between clock edges while stalled -> o_valid drops to 0 before the next edge.
